alu_stimulus_gen: RTL and testbench

Self-checking stimulus source for the ALU tester. It drives operands and opcode into the ALU under test and drives the 15-bit expected word (`res_exp`) into the comparator, delayed to line up with the ALU output. It then reads back the comparator's 8-bit error flag and counts mismatches over a fixed-length run. It is the producing end of the `res_exp`/`ErrOut` interface and sits alongside the comparator in the tester top level.

---
 rtl/alu_stimulus_gen_if.sv | 11 +
 rtl/alu_stimulus_gen.sv | 105 ++++++++++
 tb/tb_alu_stimulus_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_stimulus_gen_if.sv
// alu_stimulus_gen_if: vector, expected-word and error-flag bundle between stimulus source and ALU/comparator
interface alu_stimulus_gen_if;
    logic [11:0] a;
    logic [11:0] b;
    logic [2:0]  opcode;
    logic        vec_valid;
    logic [14:0] res_exp;
    logic [7:0]  err_in;
    modport master (output a, b, opcode, vec_valid, res_exp, input err_in);
    modport slave (input a, b, opcode, vec_valid, res_exp, output err_in);
endinterface

// File: rtl/alu_stimulus_gen.sv
// alu_stimulus_gen: LFSR-driven ALU vector source with aligned expected word and mismatch counter
module alu_stimulus_gen #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned CHECK_DELAY = 1,
    parameter logic [23:0] SEED        = 24'hACE135
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    alu_stimulus_gen_if.master alu,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [15:0]        err_count
);
    localparam int unsigned L = ALU_LATENCY;
    localparam int unsigned C = CHECK_DELAY;
    localparam logic [23:0] POLY = 24'hC20001;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [23:0] lfsr, vec_lfsr, lfsr_n;
    logic [15:0] idx, vec_idx;
    logic [3:0]  drain_cnt;
    logic        launch, last, issue, drain_end;
    logic [11:0] a_n, b_n, r_n;
    logic [2:0]  op_n;
    logic [14:0] exp_pipe [L+1];
    logic [L:0]  exp_vld;
    logic [C-1:0] chk;

    always_comb begin
        launch    = (state == IDLE || state == DONE) && start;
        last      = idx == 16'(NUM_VECTORS - 1);
        issue     = launch || (state == RUN && !last);
        drain_end = drain_cnt == 4'(L + C - 1);
        vec_lfsr  = launch ? SEED : lfsr;
        vec_idx   = launch ? 16'd0 : idx + 16'd1;
        lfsr_n    = {vec_lfsr[22:0], 1'b0} ^ (vec_lfsr[23] ? POLY : 24'd0);
        a_n       = vec_lfsr[23:12];
        b_n       = vec_idx[5:3] == 3'b000 ? a_n : vec_lfsr[11:0];
        op_n      = vec_idx[2:0];
        r_n       = op_n == 3'd0 ? a_n + b_n :
                    op_n == 3'd1 ? a_n - b_n :
                    op_n == 3'd2 ? a_n & b_n :
                    op_n == 3'd3 ? a_n | b_n :
                    op_n == 3'd4 ? a_n ^ b_n :
                    op_n == 3'd5 ? ~a_n :
                    op_n == 3'd6 ? {a_n[10:0], 1'b0} : {1'b0, a_n[11:1]};
    end

    always_ff @(posedge clock)
        state <= reset ? IDLE : state_n;

    always_comb
        state_n = launch                        ? RUN   :
                  (state == RUN && last)        ? DRAIN :
                  (state == DRAIN && drain_end) ? DONE  : state;

    always_comb begin
        busy = state == RUN || state == DRAIN;
        done = state == DONE;
        pass = done && err_count == 16'd0;
    end

    assign alu.res_exp = exp_pipe[L];

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr          <= SEED;
            idx           <= '0;
            drain_cnt     <= '0;
            alu.a         <= '0;
            alu.b         <= '0;
            alu.opcode    <= '0;
            alu.vec_valid <= 1'b0;
            exp_vld       <= '0;
            chk           <= '0;
            err_count     <= '0;
            for (int k = 0; k <= L; k++) exp_pipe[k] <= '0;
        end else begin
            drain_cnt     <= state == DRAIN ? drain_cnt + 4'd1 : 4'd0;
            alu.vec_valid <= issue;
            if (issue) begin
                lfsr       <= lfsr_n;
                idx        <= vec_idx;
                alu.a      <= a_n;
                alu.b      <= b_n;
                alu.opcode <= op_n;
                exp_pipe[0] <= {a_n > b_n, a_n == b_n, a_n < b_n, r_n};
            end
            // data stages only advance with a valid word so res_exp holds its last value
            exp_vld[0] <= issue;
            for (int k = 1; k <= L; k++) begin
                exp_vld[k] <= exp_vld[k-1];
                if (exp_vld[k-1]) exp_pipe[k] <= exp_pipe[k-1];
            end
            chk[0] <= exp_vld[L];
            for (int k = 1; k < C; k++) chk[k] <= chk[k-1];
            err_count <= launch ? 16'd0 :
                         (busy && chk[C-1] && alu.err_in != 8'd0 && err_count != 16'hFFFF) ? err_count + 16'd1 :
                         err_count;
        end
    end
endmodule

// File: tb/tb_alu_stimulus_gen.sv
// tb_alu_stimulus_gen: directed checks of two generator instances against an LFSR/ALU reference
module tb_alu_stimulus_gen;
    logic clock = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic st = 1'b0;
    logic [7:0] err_drv = 8'h00;
    int passed = 0;
    int total = 0;
    logic [31:0] ea [256];
    logic [31:0] eb [256];
    logic [31:0] eop [256];
    logic [31:0] er [256];
    logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [15:0] cnt_a, cnt_b;
    logic [31:0] o_a, o_b, o_op, o_vv, o_res, o_busy, o_done, o_pass, o_cnt;

    always #5 clock = ~clock;

    alu_stimulus_gen_if ifa ();
    alu_stimulus_gen_if ifb ();
    assign ifa.err_in = sel ? 8'h00 : err_drv;
    assign ifb.err_in = sel ? err_drv : 8'h00;

    alu_stimulus_gen dut_a (.clock(clock), .reset(rst), .start(st && !sel), .alu(ifa),
                            .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(cnt_a));
    alu_stimulus_gen #(.NUM_VECTORS(16), .ALU_LATENCY(3), .CHECK_DELAY(2)) dut_b (
        .clock(clock), .reset(rst), .start(st && sel), .alu(ifb),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(cnt_b));

    assign o_a    = sel ? 32'(ifb.a) : 32'(ifa.a);
    assign o_b    = sel ? 32'(ifb.b) : 32'(ifa.b);
    assign o_op   = sel ? 32'(ifb.opcode) : 32'(ifa.opcode);
    assign o_vv   = sel ? 32'(ifb.vec_valid) : 32'(ifa.vec_valid);
    assign o_res  = sel ? 32'(ifb.res_exp) : 32'(ifa.res_exp);
    assign o_busy = sel ? 32'(busy_b) : 32'(busy_a);
    assign o_done = sel ? 32'(done_b) : 32'(done_a);
    assign o_pass = sel ? 32'(pass_b) : 32'(pass_a);
    assign o_cnt  = sel ? 32'(cnt_b) : 32'(cnt_a);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [23:0] step(input logic [23:0] s);
        logic fb;
        fb = s[23];
        return {s[22:0], 1'b0} ^ {fb, fb, 4'b0, fb, 16'b0, fb};
    endfunction

    function automatic logic [31:0] alu_ref(input logic [11:0] x, input logic [11:0] y, input logic [2:0] op);
        logic [11:0] r;
        case (op)
            3'd0: r = x + y;
            3'd1: r = x - y;
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = ~x;
            3'd6: r = {x[10:0], 1'b0};
            default: r = {1'b0, x[11:1]};
        endcase
        return 32'({x > y, x == y, x < y, r});
    endfunction

    task automatic check_zero(input string tag);
        check({tag, " a"}, o_a, 32'd0);
        check({tag, " b"}, o_b, 32'd0);
        check({tag, " opcode"}, o_op, 32'd0);
        check({tag, " vec_valid"}, o_vv, 32'd0);
        check({tag, " res_exp"}, o_res, 32'd0);
        check({tag, " busy"}, o_busy, 32'd0);
        check({tag, " done"}, o_done, 32'd0);
        check({tag, " pass"}, o_pass, 32'd0);
        check({tag, " err_count"}, o_cnt, 32'd0);
    endtask

    task automatic run(input bit s, input int n, input int l, input int cc, input bit inj, input bit poke, input int errs);
        int fin;
        fin = 1 + n + l + cc;
        sel = s;
        st = 1'b1;
        tick;
        st = 1'b0;
        for (int c = 1; c <= fin; c++) begin
            int v, r, e;
            v = c - 1;
            r = c - 1 - l;
            e = c - 1 - l - cc;
            if (v < n) begin
                check($sformatf("a[%0d]", v), o_a, ea[v]);
                check($sformatf("b[%0d]", v), o_b, eb[v]);
                check($sformatf("opcode[%0d]", v), o_op, eop[v]);
                check($sformatf("vec_valid[%0d]", v), o_vv, 32'd1);
            end else begin
                check($sformatf("vec_valid low c%0d", c), o_vv, 32'd0);
                check($sformatf("a hold c%0d", c), o_a, ea[n-1]);
                check($sformatf("opcode hold c%0d", c), o_op, eop[n-1]);
            end
            if (r >= 0 && r < n) check($sformatf("res_exp[%0d]", r), o_res, er[r]);
            if (r >= n) check($sformatf("res_exp hold c%0d", c), o_res, er[n-1]);
            if (s && r >= 0 && r < 8) check($sformatf("aeqb only[%0d]", r), 32'(o_res[14:12]), 32'h2);
            if (c == 1) begin
                check("vec0 a", o_a, 32'hACE);
                check("vec0 b", o_b, 32'hACE);
                check("restart err_count", o_cnt, 32'd0);
            end
            if (r == 0) check("vec0 res_exp", o_res, 32'h259C);
            check($sformatf("busy c%0d", c), o_busy, 32'(c < fin));
            check($sformatf("done c%0d", c), o_done, 32'(c == fin));
            check($sformatf("pass c%0d", c), o_pass, 32'(c == fin && errs == 0));
            err_drv = (e < 0 || (inj && (e == 5 || e == 200))) ? 8'hFF : 8'h00;
            st = poke && (c == 50 || c == n + 1);
            if (c < fin) tick;
        end
        err_drv = 8'h00;
        st = 1'b0;
        check("final err_count", o_cnt, 32'(errs));
        check("final pass", o_pass, 32'(errs == 0));
    endtask

    initial begin
        logic [23:0] s;
        logic [11:0] bb;
        s = 24'hACE135;
        for (int i = 0; i < 256; i++) begin
            bb = (i[5:3] == 3'b000) ? s[23:12] : s[11:0];
            ea[i] = 32'(s[23:12]);
            eb[i] = 32'(bb);
            eop[i] = 32'(i[2:0]);
            er[i] = alu_ref(s[23:12], bb, i[2:0]);
            s = step(s);
        end
        repeat (3) tick;
        rst = 1'b0;
        sel = 1'b0;
        check_zero("reset A");
        sel = 1'b1;
        #1;
        check_zero("reset B");
        sel = 1'b0;
        err_drv = 8'hFF;
        repeat (5) tick;
        run(1'b0, 256, 1, 1, 1'b0, 1'b0, 0);
        run(1'b0, 256, 1, 1, 1'b1, 1'b1, 2);
        st = 1'b1;
        tick;
        st = 1'b0;
        err_drv = 8'hFF;
        repeat (99) tick;
        check("mid-run errors seen", 32'(o_cnt != 32'd0), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        err_drv = 8'h00;
        check_zero("mid-run reset");
        run(1'b0, 256, 1, 1, 1'b0, 1'b0, 0);
        run(1'b1, 16, 3, 2, 1'b0, 1'b0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
